// File: rtl/alu_pkg.sv
// Shared constants and types for the operand-fetch / ALU boundary.
// Opcode values mirror the ALU's opcode definitions; OP_NOTHING marks an empty slot.
package alu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREG   = 32;
    localparam int unsigned OPC_W  = 11;
    localparam int unsigned REG_AW = $clog2(NREG);

    localparam logic [OPC_W-1:0] OP_NOTHING = 11'd0;
    localparam logic [OPC_W-1:0] OP_ADD     = 11'd1;
    localparam logic [OPC_W-1:0] OP_SUB     = 11'd2;
    localparam logic [OPC_W-1:0] OP_AND     = 11'd3;
    localparam logic [OPC_W-1:0] OP_OR      = 11'd4;
    localparam logic [OPC_W-1:0] OP_XOR     = 11'd5;
    localparam logic [OPC_W-1:0] OP_SLL     = 11'd6;
    localparam logic [OPC_W-1:0] OP_SRL     = 11'd7;
    localparam logic [OPC_W-1:0] OP_SRA     = 11'd8;
    localparam logic [OPC_W-1:0] OP_SLT     = 11'd9;
    localparam logic [OPC_W-1:0] OP_SLTU    = 11'd10;

    localparam logic [3:0] TYPE_RTYPE = 4'd1;
    localparam logic [3:0] TYPE_ITYPE = 4'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [OPC_W-1:0]  opcode;
        logic [XLEN-1:0]   value1;
        logic [XLEN-1:0]   value2;
        logic [31:0]       immediate;
        logic [5:0]        shamt;
        logic [3:0]        instr_type;
    } exec_slot_t;

    // Slot holds an instruction that will produce a register result.
    function automatic logic slot_writes(exec_slot_t s);
        return s.valid && (s.rd != '0) && (s.opcode != OP_NOTHING);
    endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one synchronous write port,
// a debug read port, x0 hardwired to zero.
module regfile
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [XLEN-1:0]   rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata2_o,
    input  logic [REG_AW-1:0] dbg_addr_i,
    output logic [XLEN-1:0]   dbg_data_o
);

    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = (raddr1_i == '0)   ? '0 : rf_q[raddr1_i];
    assign rdata2_o   = (raddr2_i == '0)   ? '0 : rf_q[raddr2_i];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: register read with execute-slot bypass, the ALU input
// register, writeback of the ALU result on retire, and a retired-instruction counter.
module operand_fetch
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [3:0]        in_instr_type,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [31:0]       in_immediate,
    input  logic [5:0]        in_shamt,
    input  logic              stall,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [XLEN-1:0]   alu_value1,
    output logic [XLEN-1:0]   alu_value2,
    output logic [31:0]       alu_immediate,
    output logic [5:0]        alu_shamt,
    output logic [3:0]        alu_instr_type,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    output logic [63:0]       retire_count
);

    exec_slot_t      slot_q, slot_d;
    logic [63:0]     retire_count_q;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2;
    logic [XLEN-1:0] src1_val, src2_val;
    logic            accept;
    logic            wb_en;

    assign in_ready = !stall;
    assign accept   = in_valid && !stall;
    assign wb_en    = !reset && !stall && slot_writes(slot_q);

    regfile u_regfile (
        .clk_i      (clk),
        .reset_i    (reset),
        .we_i       (wb_en),
        .waddr_i    (slot_q.rd),
        .wdata_i    (alu_result),
        .raddr1_i   (in_rs1),
        .rdata1_o   (rf_rdata1),
        .raddr2_i   (in_rs2),
        .rdata2_o   (rf_rdata2),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // The producer in execute writes on the same edge we read, so forward its result.
    always_comb begin
        src1_val = rf_rdata1;
        src2_val = rf_rdata2;
        if (in_rs1 == '0) begin
            src1_val = '0;
        end else if (slot_writes(slot_q) && (slot_q.rd == in_rs1)) begin
            src1_val = alu_result;
        end
        if (in_rs2 == '0) begin
            src2_val = '0;
        end else if (slot_writes(slot_q) && (slot_q.rd == in_rs2)) begin
            src2_val = alu_result;
        end
    end

    always_comb begin
        slot_d        = '0;
        slot_d.opcode = OP_NOTHING;
        if (accept) begin
            slot_d.valid      = 1'b1;
            slot_d.rd         = in_rd;
            slot_d.opcode     = in_opcode;
            slot_d.value1     = src1_val;
            slot_d.value2     = src2_val;
            slot_d.immediate  = in_immediate;
            slot_d.shamt      = in_shamt;
            slot_d.instr_type = in_instr_type;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q         <= '0;
            slot_q.opcode  <= OP_NOTHING;
            retire_count_q <= '0;
        end else if (!stall) begin
            slot_q <= slot_d;
            if (slot_q.valid) begin
                retire_count_q <= retire_count_q + 64'd1;
            end
        end
    end

    assign alu_opcode     = slot_q.opcode;
    assign alu_value1     = slot_q.value1;
    assign alu_value2     = slot_q.value2;
    assign alu_immediate  = slot_q.immediate;
    assign alu_shamt      = slot_q.shamt;
    assign alu_instr_type = slot_q.instr_type;
    assign retire_count   = retire_count_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small reference ALU closing the loop on alu_result.
module tb_operand_fetch;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [3:0]        in_instr_type;
    logic [REG_AW-1:0] in_rs1, in_rs2, in_rd;
    logic [31:0]       in_immediate;
    logic [5:0]        in_shamt;
    logic              stall;
    logic [OPC_W-1:0]  alu_opcode;
    logic [XLEN-1:0]   alu_value1, alu_value2;
    logic [31:0]       alu_immediate;
    logic [5:0]        alu_shamt;
    logic [3:0]        alu_instr_type;
    logic [XLEN-1:0]   alu_result;
    logic [REG_AW-1:0] dbg_addr;
    logic [XLEN-1:0]   dbg_data;
    logic [63:0]       retire_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_instr_type  (in_instr_type),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .in_immediate   (in_immediate),
        .in_shamt       (in_shamt),
        .stall          (stall),
        .alu_opcode     (alu_opcode),
        .alu_value1     (alu_value1),
        .alu_value2     (alu_value2),
        .alu_immediate  (alu_immediate),
        .alu_shamt      (alu_shamt),
        .alu_instr_type (alu_instr_type),
        .alu_result     (alu_result),
        .dbg_addr       (dbg_addr),
        .dbg_data       (dbg_data),
        .retire_count   (retire_count)
    );

    // Reference ALU: only ADD/SUB are exercised; ITYPE uses the sign-extended immediate.
    logic [XLEN-1:0] op_b;
    always_comb begin
        op_b = (alu_instr_type == TYPE_ITYPE) ? {{32{alu_immediate[31]}}, alu_immediate}
                                              : alu_value2;
        case (alu_opcode)
            OP_ADD:  alu_result = alu_value1 + op_b;
            OP_SUB:  alu_result = alu_value1 - op_b;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OPC_W-1:0] op, input logic [3:0] ty,
                         input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        in_valid      = 1'b1;
        in_opcode     = op;
        in_instr_type = ty;
        in_rd         = REG_AW'(rd);
        in_rs1        = REG_AW'(rs1);
        in_rs2        = REG_AW'(rs2);
        in_immediate  = imm;
        in_shamt      = 6'd0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] peek_setup(input int idx);
        return 64'(idx);
    endfunction

    task automatic peek(input string tag, input int idx, input logic [63:0] exp);
        dbg_addr = REG_AW'(idx);
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        dbg_addr = '0;
        idle();
        in_opcode = OP_NOTHING; in_instr_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_immediate = '0; in_shamt = '0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("reset_opcode", 64'(alu_opcode), 64'(OP_NOTHING));
        check("reset_count", retire_count, 64'd0);
        check("reset_value1", alu_value1, 64'd0);
        for (int i = 0; i < 32; i++) peek("reset_rf", i, 64'd0);

        // Basic write then read: ADD x5 = x0 + 7
        drive(OP_ADD, TYPE_ITYPE, 5, 0, 0, 32'd7);
        tick();
        idle();
        check("basic_opcode", 64'(alu_opcode), 64'(OP_ADD));
        check("basic_imm", 64'(alu_immediate), 64'd7);
        tick();
        check("basic_empty_opc", 64'(alu_opcode), 64'(OP_NOTHING));
        check("basic_empty_imm", 64'(alu_immediate), 64'd0);
        tick();
        peek("basic_x5", 5, 64'd7);
        check("basic_count", retire_count, 64'd1);

        // Back-to-back bypass: x1 = x0 + 5; x2 = x1 + x1
        drive(OP_ADD, TYPE_ITYPE, 1, 0, 0, 32'd5);
        tick();
        drive(OP_ADD, TYPE_RTYPE, 2, 1, 1, 32'd0);
        check("b2b_ready", 64'(in_ready), 64'd1);
        tick();
        idle();
        check("b2b_value1", alu_value1, 64'd5);
        check("b2b_value2", alu_value2, 64'd5);
        peek("b2b_x1", 1, 64'd5);
        tick();
        peek("b2b_x2", 2, 64'd10);
        check("b2b_count", retire_count, 64'd3);

        // Stall: x3 = x2 - x1 held for 3 cycles
        drive(OP_SUB, TYPE_RTYPE, 3, 2, 1, 32'd0);
        tick();
        idle();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_opcode", 64'(alu_opcode), 64'(OP_SUB));
            check("stall_value1", alu_value1, 64'd10);
            check("stall_value2", alu_value2, 64'd5);
            check("stall_ready", 64'(in_ready), 64'd0);
            peek("stall_x3", 3, 64'd0);
            check("stall_count", retire_count, 64'd3);
        end
        stall = 1'b0;
        tick();
        peek("stall_x3_after", 3, 64'd5);
        check("stall_count_after", retire_count, 64'd4);

        // x0 guard: write to x0 then read x0 back-to-back
        drive(OP_ADD, TYPE_ITYPE, 0, 0, 0, 32'd99);
        tick();
        drive(OP_ADD, TYPE_RTYPE, 6, 0, 0, 32'd0);
        tick();
        idle();
        check("x0_value1", alu_value1, 64'd0);
        check("x0_value2", alu_value2, 64'd0);
        tick();
        peek("x0_rf", 0, 64'd0);
        peek("x0_x6", 6, 64'd0);
        check("x0_count", retire_count, 64'd6);

        // Reset mid-flight: x4 = x0 + 1 discarded
        drive(OP_ADD, TYPE_ITYPE, 4, 0, 0, 32'd1);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        peek("rst_x4", 4, 64'd0);
        peek("rst_x3", 3, 64'd0);
        check("rst_count", retire_count, 64'd0);
        check("rst_opcode", 64'(alu_opcode), 64'(OP_NOTHING));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the execute ALU.
- Holds the 32 x 64-bit integer register file and accepts decoded instructions over a valid/ready handshake.
- Reads rs1/rs2 with bypass from the instruction currently in execute, and registers opcode/operands/immediate/shamt/type into the ALU input register.
- Captures the ALU's combinational result and writes it back to rd when the execute slot retires.

Parameters:
- XLEN, 64, datapath width
- NREG, 32, architectural registers (address width = $clog2(NREG))
- OPC_W, 11, opcode width (matches Alu.defs encodings)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  OPC_W  ALU opcode (`ADD, `SUB, ..., `NOTHING)
- in_instr_type  in  4  `RTYPE / `ITYPE / other
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_immediate  in  32  signed immediate
- in_shamt  in  6  shift amount
- stall  in  1  downstream hold; freezes the execute slot
- alu_opcode  out  OPC_W  to ALU; `NOTHING when slot empty
- alu_value1, alu_value2  out  XLEN  operand values
- alu_immediate  out  32; alu_shamt  out  6; alu_instr_type  out  4
- alu_result  in  XLEN  combinational ALU result for the current slot
- dbg_addr  in  5; dbg_data  out  XLEN  combinational regfile peek (x0 reads 0)
- retire_count  out  64  instructions written back or retired

Behaviour:
- Slot state: one execute register holding {valid, rd, opcode, value1, value2, immediate, shamt, instr_type}.
- in_ready = !stall. An instruction is accepted on a posedge where in_valid && in_ready.
- Latency: accepted at edge N, presented on alu_* during cycle N+1, retired at the first edge >= N+2 where stall=0.
- Retire (slot valid && !stall at posedge):
  - if rd != 0 and opcode != `NOTHING, regfile[rd] <= alu_result;
  - retire_count increments by 1.
- An incoming instruction is loaded into the slot on the same edge the old one retires (back-to-back, 1 instr/cycle).
- No accept while stall=1: the slot and its alu_* outputs are held bit-stable, so the ALU output is stable.
- On an edge with no accept and stall=0, the slot becomes empty:
  - valid=0, alu_opcode=`NOTHING;
  - values, immediate and shamt go to 0.
- Operand read at accept, per source s in {rs1, rs2}:
  - s == 0: value 0;
  - else if slot valid && slot.rd == s && slot.opcode != `NOTHING: alu_result (bypass; write-after-read in the same edge resolves to the new value);
  - else regfile[s].
- alu_value2 is always the rs2 read, even for ITYPE; the ALU selects the immediate itself.
- x0: writes to x0 are dropped; reads are always 0; bypass is never taken for index 0.
- Reset: regfile all zero; slot valid=0; alu_opcode=`NOTHING; alu_value1, alu_value2, alu_immediate, alu_shamt, alu_instr_type = 0; retire_count=0.
- Reset while the slot is valid: the in-flight instruction is discarded with no writeback and no count.
- reset has priority over every other event.
- stall asserted with an empty slot: no effect except in_ready=0.
- retire_count wraps modulo 2^64.
- dbg_data is a pure combinational read of the array and does not see the bypass.

Decomposition:
- Shared package alu_pkg:
  - XLEN and NREG constants;
  - opcode localparams mirroring Alu.defs (`ADD..`NOTHING);
  - instruction-type constants `RTYPE/`ITYPE;
  - exec_slot_t struct {valid, rd, opcode, value1, value2, immediate, shamt, instr_type}.
- One sub-module, regfile: NREG x XLEN array with two combinational read ports, one synchronous write port, x0 hardwired to 0, and a debug read port.
- operand_fetch owns the slot register, bypass mux, handshake and retire counter.

Test Plan:
- Reset check: assert reset 2 cycles -> alu_opcode=`NOTHING, retire_count=0, and dbg_data=0 for all 32 indices.
- Basic write then read: issue ADD rd=5 rs1=0 ITYPE imm=7, tie alu_result to a reference ALU model, then idle 2 cycles -> dbg_addr=5 gives 7; retire_count=1.
- Back-to-back bypass: ADD x1=x0+5 (ITYPE), then immediately ADD x2=x1+x1 (RTYPE) -> second alu_value1 = alu_value2 = 5; x2=10; no bubble, in_ready stays 1.
- Stall: issue SUB x3=x2-x1, hold stall=1 for 3 cycles -> alu_* stable for 3 cycles, in_ready=0, x3 unwritten; release -> x3=5, retire_count increments once.
- x0 guard: ADD rd=0 rs1=0 imm=99, then an instruction reading rs1=0 -> x0 stays 0, no bypass, operand reads 0; retire_count still increments.
- Reset mid-flight: accept ADD x4=x0+1, assert reset the next cycle -> x4=0, retire_count=0, alu_opcode=`NOTHING.
